kbd_fifo_ctrl: RTL and testbench
================================

# kbd_fifo_ctrl

Controller that shares the keyboard byte FIFO between two byte producers and drains it toward one consumer. On the write side it performs round-robin arbitration between source 0 (PS/2 scan-code decoder) and source 1 (UART receive path). It tags each byte with its source bit and pushes it into the FIFO instance. On the read side a small state machine pops the FIFO, captures its registered read data, and presents each byte on a valid/ready port to the text-writer logic.

## Interface
- DW, 8, payload width per source; the FIFO instance is built with WIDTH = DW+1 (MSB = source tag).
- clk  in  1  system clock, all logic on posedge.
- resetn  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- src0_valid  in  1  source 0 has a byte; held until accepted.
- src0_data  in  DW  source 0 byte.
- src0_ready  out  1  source 0 byte accepted this cycle (combinational).
- src1_valid  in  1  source 1 has a byte; held until accepted.
- src1_data  in  DW  source 1 byte.
- src1_ready  out  1  source 1 byte accepted this cycle (combinational).
- fifo_push  out  1  to FIFO push.
- fifo_wdata  out  DW+1  to FIFO inData: {tag, data}.
- fifo_notfull  in  1  from FIFO notfull (registered in FIFO).
- fifo_notempty  in  1  from FIFO notempty (registered in FIFO).
- fifo_pop  out  1  to FIFO pop (combinational).
- fifo_rdata  in  DW+1  from FIFO outData; valid the cycle after a pop only.
- out_valid  out  1  out_data/out_src valid.
- out_data  out  DW  captured byte.
- out_src  out  1  0 = source 0, 1 = source 1.
- out_ready  in  1  consumer accepts when out_valid & out_ready.

## Operation
- Write arbiter: register rr (1 bit, reset 0) names the favoured source.
  - Only one srcN_valid: that source wins.
  - Both valid: source rr wins.
- fifo_push = fifo_notfull & (src0_valid | src1_valid). fifo_wdata = {winner, winner data}. srcN_ready = fifo_push & (winner == N).
- After any push, rr <= ~winner. This holds even when only one source was valid. Without a push, rr holds.
- fifo_notfull = 0: no push, both readys 0, sources hold data, rr unchanged. The FIFO drives notfull = 0 through reset and for the first cycle after resetn rises, so the first push occurs at the earliest 2 cycles after reset release.
- Read FSM states: IDLE, CAP, HOLD. 2-bit state; unused encoding goes to IDLE.
  - IDLE: fifo_pop = fifo_notempty. If fifo_pop, go to CAP.
  - CAP: fifo_pop = 0. Register out_data <= fifo_rdata[DW-1:0], out_src <= fifo_rdata[DW], out_valid <= 1. Go to HOLD.
  - HOLD: out_valid = 1, and out_data/out_src stay stable until the handshake.
    - On out_ready: out_valid <= 0. If fifo_notempty, assert fifo_pop in the same cycle and go to CAP; otherwise go to IDLE.
    - Without out_ready: fifo_pop = 0, stay in HOLD.
- The read side never pops while a byte is pending, so at most one FIFO entry is in flight. No byte is ever dropped or duplicated.
- Push and pop are independent and may occur in the same cycle.

## Timing
- Reset values: state = IDLE, rr = 0, out_valid = 0, out_data = 0, out_src = 0. Combinational outputs (fifo_push, fifo_pop, srcN_ready) evaluate to 0 while resetn = 0, regardless of inputs.
- Write latency: a byte is accepted in the same cycle as srcN_ready. It becomes visible to FIFO notempty 1 cycle later.
- Read latency:
  - pop in cycle t (IDLE)
  - capture in t+1 (CAP)
  - out_valid = 1 from t+2
- Sustained drain rate is 1 byte per 2 cycles with out_ready held high. The out_valid high cycles are HOLD; CAP cycles are low.
- Both sources continuously valid with FIFO never full: pushes alternate 0,1,0,1… and each source gets exactly one push per 2 cycles.
- Reset mid-operation: all registers return to reset values on the next edge. A byte pending in HOLD is discarded. The FIFO shares resetn, so its contents are discarded too.
- Deassertion of srcN_valid before ready is a protocol violation; the block does not detect it.

## Test plan
- Reset release, src0 sends 0x1C: src0_ready = 0 at cycles 0–1, push at cycle 2 with fifo_wdata = 0x01C. The byte is popped in a later IDLE cycle with fifo_notempty = 1, and out_valid rises 2 cycles after that pop with out_data = 0x1C, out_src = 0.
- Both sources always valid (src0 = 0xA0.., src1 = 0xB0.., incrementing), out_ready = 1: output order is A0, B0, A1, B1… with out_src alternating 0,1, and no byte is lost.
- out_ready held 0 for 20 cycles while both sources push 8 bytes each: pushes stall while fifo_notfull = 0, readys stay 0, and rr does not advance. After out_ready is released, all 16 bytes emerge in arbitration order.
- out_ready toggled randomly: out_data/out_src are stable whenever out_valid = 1 and out_ready = 0, fifo_pop is never asserted in CAP, and it is never asserted in HOLD without out_ready.
- Only src1 valid (0x55, 0x66), then both valid: rr = 0 after src1's last push, so src0 wins the first contended cycle.
- Assert resetn = 0 for 1 cycle while in HOLD with out_valid = 1: out_valid = 0 and state = IDLE on the next cycle, rr = 0, and no stale byte appears afterwards.

Source files
------------

// File: rtl/kbd_fifo_ctrl.sv
// Keyboard byte FIFO controller: round-robin write arbiter for two byte
// producers, plus a read FSM that pops one entry at a time toward a consumer.
module kbd_fifo_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  input  logic          src0_valid_i,
  input  logic [DW-1:0] src0_data_i,
  output logic          src0_ready_o,
  input  logic          src1_valid_i,
  input  logic [DW-1:0] src1_data_i,
  output logic          src1_ready_o,
  output logic          fifo_push_o,
  output logic [DW:0]   fifo_wdata_o,
  input  logic          fifo_notfull_i,
  input  logic          fifo_notempty_i,
  output logic          fifo_pop_o,
  input  logic [DW:0]   fifo_rdata_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_src_o,
  input  logic          out_ready_i,
  output logic [1:0]    state_o,
  output logic          rr_o
);

  // Handshakes: a source byte transfers in a cycle where srcN_valid & srcN_ready;
  // an output byte transfers in a cycle where out_valid & out_ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAP  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_src_q, out_src_d;
  logic          winner;
  logic          push;
  logic          pop;

  // Source 1 wins when it is the only requester, or when both request and it is favoured.
  always_comb begin
    winner = src1_valid_i & (~src0_valid_i | rr_q);
    push   = resetn_i & fifo_notfull_i & (src0_valid_i | src1_valid_i);
    rr_d   = push ? ~winner : rr_q;
  end

  assign fifo_push_o  = push;
  assign fifo_wdata_o = {winner, (winner ? src1_data_i : src0_data_i)};
  assign src0_ready_o = push & ~winner;
  assign src1_ready_o = push & winner;

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    case (state_q)
      S_IDLE: begin
        if (fifo_notempty_i) begin
          pop     = 1'b1;
          state_d = S_CAP;
        end
      end
      S_CAP: begin
        out_data_d  = fifo_rdata_i[DW-1:0];
        out_src_d   = fifo_rdata_i[DW];
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (fifo_notempty_i) begin
            pop     = 1'b1;
            state_d = S_CAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_pop_o = pop & resetn_i;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
  assign state_o     = state_q;
  assign rr_o        = rr_q;

endmodule

// File: tb/tb_kbd_fifo_ctrl.sv
// Bench for kbd_fifo_ctrl: a queue-based FIFO model, two byte sources and a
// spec-level arbitration/drain model feeding an expected-byte queue.
module tb_kbd_fifo_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          sv [2];
  logic [DW-1:0] sd [2];
  logic          src0_ready, src1_ready;
  logic          fifo_push, fifo_pop;
  logic [DW:0]   fifo_wdata;
  logic          f_notfull, f_notempty, f_init;
  logic [DW:0]   f_rdata;
  logic          out_valid, out_src, out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    state_dbg;
  logic          rr_dbg;

  kbd_fifo_ctrl #(.DW(DW)) dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .src0_valid_i   (sv[0]),
    .src0_data_i    (sd[0]),
    .src0_ready_o   (src0_ready),
    .src1_valid_i   (sv[1]),
    .src1_data_i    (sd[1]),
    .src1_ready_o   (src1_ready),
    .fifo_push_o    (fifo_push),
    .fifo_wdata_o   (fifo_wdata),
    .fifo_notfull_i (f_notfull),
    .fifo_notempty_i(f_notempty),
    .fifo_pop_o     (fifo_pop),
    .fifo_rdata_i   (f_rdata),
    .out_valid_o    (out_valid),
    .out_data_o     (out_data),
    .out_src_o      (out_src),
    .out_ready_i    (out_ready),
    .state_o        (state_dbg),
    .rr_o           (rr_dbg)
  );

  // FIFO model: registered flags, notfull held low one extra cycle after reset.
  logic [DW:0] fq [$];
  always @(posedge clk) begin
    if (!resetn) begin
      fq.delete();
      f_notfull  <= 1'b0;
      f_notempty <= 1'b0;
      f_init     <= 1'b0;
      f_rdata    <= '0;
    end else begin
      if (fifo_pop) f_rdata <= (fq.size() > 0) ? fq.pop_front() : '0;
      if (fifo_push) fq.push_back(fifo_wdata);
      f_init     <= 1'b1;
      f_notfull  <= f_init && (fq.size() < DEPTH);
      f_notempty <= (fq.size() > 0);
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [DW:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic fav;
  logic pop_d1, pop_d2, ov_d1, rdy_d1;
  logic [1:0] acc;

  // Source streams
  int            s_left [2];
  logic [DW-1:0] s_step [2];
  bit            s_rand [2];
  int            ready_mode;  // 0 low, 1 high, 2 random

  task automatic model_reset();
    fav    = 1'b0;
    pop_d1 = 1'b0;
    pop_d2 = 1'b0;
    ov_d1  = 1'b0;
    rdy_d1 = 1'b0;
    acc    = 2'b00;
    exp_q.delete();
  endtask

  task automatic sample();
    logic e_push, e_win, e_ov, e_pop;
    @(negedge clk);
    if (!resetn) begin
      check_eq("rst_push", 32'(fifo_push), 0);
      check_eq("rst_pop", 32'(fifo_pop), 0);
      check_eq("rst_rdy0", 32'(src0_ready), 0);
      check_eq("rst_rdy1", 32'(src1_ready), 0);
      model_reset();
      return;
    end
    // write side: lone requester wins, contention goes to the favoured source
    e_push = f_notfull & (sv[0] | sv[1]);
    e_win  = (sv[0] & sv[1]) ? fav : sv[1];
    check_eq("rr", 32'(rr_dbg), 32'(fav));
    check_eq("push", 32'(fifo_push), 32'(e_push));
    check_eq("rdy0", 32'(src0_ready), 32'(e_push & ~e_win));
    check_eq("rdy1", 32'(src1_ready), 32'(e_push & e_win));
    if (e_push) check_eq("wdata", 32'(fifo_wdata), 32'({e_win, sd[e_win]}));
    acc[0] = e_push & ~e_win;
    acc[1] = e_push & e_win;
    // read side: valid two cycles after a pop, held until accepted
    e_ov  = pop_d2 | (ov_d1 & ~rdy_d1);
    e_pop = f_notempty & ~pop_d1 & (~e_ov | out_ready);
    check_eq("out_valid", 32'(out_valid), 32'(e_ov));
    check_eq("pop", 32'(fifo_pop), 32'(e_pop));
    if (e_ov) begin
      check_eq("exp_q_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        check_eq("out_byte", 32'({out_src, out_data}), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    pop_d2 = pop_d1;
    pop_d1 = e_pop;
    ov_d1  = e_ov;
    rdy_d1 = out_ready;
    if (e_push) begin
      exp_q.push_back({e_win, sd[e_win]});
      fav = ~e_win;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic advance();
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (acc[n]) begin
        s_left[n]--;
        sd[n] = sd[n] + s_step[n];
        sv[n] = 1'b0;
      end
      if (!sv[n] && s_left[n] > 0) sv[n] = s_rand[n] ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    acc = 2'b00;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic start_src(input int n, input logic [DW-1:0] base, input logic [DW-1:0] step,
                           input int count);
    sd[n]     = base;
    s_step[n] = step;
    s_left[n] = count;
    sv[n]     = 1'b1;
  endtask

  task automatic do_reset();
    for (int n = 0; n < 2; n++) begin
      sv[n]     = 1'b0;
      s_left[n] = 0;
    end
    resetn = 1'b0;
    sample();
    advance();
    resetn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    model_reset();
    for (int n = 0; n < 2; n++) begin
      sv[n] = 1'b0; sd[n] = '0; s_left[n] = 0; s_step[n] = 8'd1; s_rand[n] = 1'b0;
    end
    ready_mode = 1;
    out_ready  = 1'b1;

    // single byte through reset release
    start_src(0, 8'h1C, 8'h01, 1);
    run(3);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      if (c == 0) begin
        check_eq("p1_state_rst", 32'(state_dbg), 0);
        check_eq("p1_valid_rst", 32'(out_valid), 0);
        check_eq("p1_data_rst", 32'({out_src, out_data}), 0);
      end
      if (c < 2) check_eq("p1_rdy0_early", 32'(src0_ready), 0);
      else begin
        check_eq("p1_push_c2", 32'(fifo_push), 1);
        check_eq("p1_wdata_c2", 32'(fifo_wdata), 32'h01C);
      end
      advance();
    end
    run(10);
    check_eq("p1_drained", 32'(exp_q.size()), 0);

    // both sources continuously valid, consumer always ready
    do_reset();
    start_src(0, 8'hA0, 8'h01, 8);
    start_src(1, 8'hB0, 8'h01, 8);
    run(50);
    check_eq("p2_drained", 32'(exp_q.size()), 0);
    check_eq("p2_src_left", 32'(s_left[0] + s_left[1]), 0);

    // consumer stalled, FIFO fills, then release
    do_reset();
    ready_mode = 0;
    out_ready  = 1'b0;
    start_src(0, 8'hC0, 8'h01, 8);
    start_src(1, 8'hD0, 8'h01, 8);
    run(20);
    ready_mode = 1;
    run(60);
    check_eq("p3_drained", 32'(exp_q.size()), 0);
    check_eq("p3_src_left", 32'(s_left[0] + s_left[1]), 0);

    // random source gaps and random consumer backpressure
    ready_mode = 2;
    s_rand[0]  = 1'b1;
    s_rand[1]  = 1'b1;
    start_src(0, 8'($urandom_range(0, 255)), 8'h03, 30);
    start_src(1, 8'($urandom_range(0, 255)), 8'h05, 30);
    run(300);
    ready_mode = 1;
    s_rand[0]  = 1'b0;
    s_rand[1]  = 1'b0;
    run(40);
    check_eq("p4_drained", 32'(exp_q.size()), 0);
    check_eq("p4_src_left", 32'(s_left[0] + s_left[1]), 0);

    // src1 alone twice, then contention: src0 must win first
    do_reset();
    start_src(1, 8'h55, 8'h11, 2);
    run(4);
    start_src(0, 8'h10, 8'h01, 3);
    start_src(1, 8'h20, 8'h01, 3);
    sample();
    check_eq("p5_rr_after_src1", 32'(rr_dbg), 0);
    check_eq("p5_src0_wins", 32'(src0_ready), 1);
    advance();
    run(30);
    check_eq("p5_drained", 32'(exp_q.size()), 0);

    // reset while a byte is held
    ready_mode = 0;
    out_ready  = 1'b0;
    start_src(0, 8'h77, 8'h01, 1);
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      sample();
      advance();
      k++;
    end
    check_eq("p6_hold_reached", 32'(out_valid), 1);
    resetn = 1'b0;
    sample();
    advance();
    resetn = 1'b1;
    sample();
    check_eq("p6_valid_cleared", 32'(out_valid), 0);
    check_eq("p6_state_idle", 32'(state_dbg), 0);
    check_eq("p6_rr_cleared", 32'(rr_dbg), 0);
    advance();
    ready_mode = 1;
    run(10);
    check_eq("p6_no_stale", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
